// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// wait-FSM states and the shadow scoreboard entry.
package hazard_ctrl_pkg;

   localparam int REG_W = 5;
   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_e;

   typedef enum logic {
      HZ_RUN  = 1'b0,
      HZ_WAIT = 1'b1
   } hz_state_e;

   typedef struct packed {
      logic             v;
      logic [REG_W-1:0] rd;
      logic             we;
      logic             ld;
   } shadow_t;

   // x0 is hard-wired, so an entry targeting it never produces a value.
   function automatic shadow_t make_entry(input logic v, input logic [REG_W-1:0] rd,
                                          input logic we, input logic ld);
      shadow_t e;
      e.v  = v;
      e.rd = rd;
      e.we = we & (rd != '0);
      e.ld = ld;
      return e;
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage decode info in, pipeline-register controls and forwarding selects out.
interface hazard_ctrl_if;
   import hazard_ctrl_pkg::*;

   logic             id_valid;
   logic [REG_W-1:0] id_rs1;
   logic [REG_W-1:0] id_rs2;
   logic             id_use_rs1;
   logic             id_use_rs2;
   logic [REG_W-1:0] id_rd;
   logic             id_rd_we;
   logic             id_is_load;
   logic             ex_redirect;
   logic             mem_wait;

   logic             stall_if;
   logic             stall_id;
   logic             bubble_ex;
   logic             flush_id;
   logic             freeze;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;
   logic             mem_timeout;

   modport master (
      output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
             id_rd, id_rd_we, id_is_load, ex_redirect, mem_wait,
      input  stall_if, stall_id, bubble_ex, flush_id, freeze,
             fwd_a, fwd_b, mem_timeout
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
             id_rd, id_rd_we, id_is_load, ex_redirect, mem_wait,
      output stall_if, stall_id, bubble_ex, flush_id, freeze,
             fwd_a, fwd_b, mem_timeout
   );

endinterface

// File: rtl/hazard_match.sv
// Compares one shadow stage's destination against the ID source registers.
module hazard_match
   import hazard_ctrl_pkg::*;
(
   input  logic             v,
   input  logic             we,
   input  logic [REG_W-1:0] rd,
   input  logic [REG_W-1:0] rs1,
   input  logic [REG_W-1:0] rs2,
   input  logic             use_rs1,
   input  logic             use_rs2,
   output logic             match1,
   output logic             match2
);

   logic live;

   assign live   = v & we & (rd != '0);
   assign match1 = live & use_rs1 & (rd == rs1);
   assign match2 = live & use_rs2 & (rd == rs2);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: shadow scoreboard of EX/MEM/WB destinations,
// stall/flush/bubble generation, registered forwarding selects and LSU wait FSM.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MAX_WAIT = 16,
   parameter bit FWD_EN   = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   hazard_ctrl_if.slave hz
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT - 1);
   localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(MAX_WAIT - 2);

   shadow_t          ex_q, mem_q, wb_q;
   hz_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;
   logic [1:0]       fwd_a_q, fwd_b_q;

   logic use1, use2;
   logic ex_m1, ex_m2, mem_m1, mem_m2, wb_m1, wb_m2;
   logic freeze, redirect, lu, raw, hold, bubble;
   logic wb_ld_unused;

   assign use1 = hz.id_valid & hz.id_use_rs1;
   assign use2 = hz.id_valid & hz.id_use_rs2;
   assign wb_ld_unused = wb_q.ld;

   hazard_match u_ex (.v(ex_q.v), .we(ex_q.we), .rd(ex_q.rd), .rs1(hz.id_rs1), .rs2(hz.id_rs2),
                      .use_rs1(use1), .use_rs2(use2), .match1(ex_m1), .match2(ex_m2));
   hazard_match u_mem (.v(mem_q.v), .we(mem_q.we), .rd(mem_q.rd), .rs1(hz.id_rs1), .rs2(hz.id_rs2),
                       .use_rs1(use1), .use_rs2(use2), .match1(mem_m1), .match2(mem_m2));
   hazard_match u_wb (.v(wb_q.v), .we(wb_q.we), .rd(wb_q.rd), .rs1(hz.id_rs1), .rs2(hz.id_rs2),
                      .use_rs1(use1), .use_rs2(use2), .match1(wb_m1), .match2(wb_m2));

   // Load data returns on the MEM result path, so a load one stage ahead of
   // its consumer (after the load-use bubble) is still taken through 01.
   function automatic logic [1:0] pick(input logic m_ex, input logic m_mem, input logic mem_ld);
      if (!FWD_EN) return FWD_RF;
      if (m_ex)    return FWD_MEM;
      if (m_mem)   return mem_ld ? FWD_MEM : FWD_WB;
      return FWD_RF;
   endfunction

   // Priority: freeze > redirect > load-use / RAW stall.
   always_comb begin
      freeze   = hz.mem_wait;
      redirect = hz.ex_redirect & ~freeze;
      lu       = ex_q.ld & (ex_m1 | ex_m2);
      raw      = ex_m1 | ex_m2 | mem_m1 | mem_m2 | wb_m1 | wb_m2;
      hold     = ~freeze & ~hz.ex_redirect & (FWD_EN ? lu : raw);
      bubble   = redirect | hold;
   end

   assign hz.freeze      = freeze;
   assign hz.flush_id    = redirect;
   assign hz.bubble_ex   = bubble;
   assign hz.stall_if    = hold;
   assign hz.stall_id    = hold;
   assign hz.fwd_a       = fwd_a_q;
   assign hz.fwd_b       = fwd_b_q;
   assign hz.mem_timeout = timeout_q;

   // NOTE: every variable gets a default at the top of an always_comb so no
   // path leaves it unassigned, which would infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      timeout_d = 1'b0;
      unique case (state_q)
         HZ_RUN:  if (hz.mem_wait)  state_d = HZ_WAIT;
         HZ_WAIT: if (!hz.mem_wait) state_d = HZ_RUN;
      endcase
      if (hz.mem_wait) begin
         cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
         timeout_d = (cnt_q == CNT_PRE) | ((MAX_WAIT == 1) && (state_q == HZ_RUN));
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q      <= '0;
         mem_q     <= '0;
         wb_q      <= '0;
         state_q   <= HZ_RUN;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
         fwd_a_q   <= FWD_RF;
         fwd_b_q   <= FWD_RF;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
         if (!freeze) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= make_entry(hz.id_valid & ~bubble & ~hz.ex_redirect,
                                hz.id_rd, hz.id_rd_we, hz.id_is_load);
            fwd_a_q <= bubble ? FWD_RF : pick(ex_m1, mem_m1, mem_q.ld);
            fwd_b_q <= bubble ? FWD_RF : pick(ex_m2, mem_m2, mem_q.ld);
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl (MAX_WAIT=16, FWD_EN=1).
module tb_hazard_ctrl;
   import hazard_ctrl_pkg::*;

   localparam logic [4:0] IDLE = 5'b00000;  // {stall_if, stall_id, bubble_ex, flush_id, freeze}
   localparam logic [4:0] LU   = 5'b11100;
   localparam logic [4:0] RDR  = 5'b00110;
   localparam logic [4:0] FRZ  = 5'b00001;

   typedef struct {
      string      tag;
      logic [9:0] val;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   hazard_ctrl_if hz ();

   hazard_ctrl #(.MAX_WAIT(16), .FWD_EN(1'b1)) dut (.clk(clk), .rst(rst), .hz(hz));

   function automatic logic [9:0] ev(input logic [4:0] ctl, input logic [1:0] fa,
                                     input logic [1:0] fb, input logic to);
      return {ctl, fa, fb, to};
   endfunction

   task automatic id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic [4:0] rd,
                     input logic we, input logic ld);
      hz.id_valid   = v;
      hz.id_rs1     = rs1;
      hz.id_rs2     = rs2;
      hz.id_use_rs1 = u1;
      hz.id_use_rs2 = u2;
      hz.id_rd      = rd;
      hz.id_rd_we   = we;
      hz.id_is_load = ld;
   endtask

   task automatic nop();
      id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   // Push the expectation for the cycle now being driven, compare at negedge.
   task automatic cyc(input string tag, input logic [9:0] e);
      exp_t       x;
      logic [9:0] obs;
      sb.push_back('{tag: tag, val: e});
      @(negedge clk);
      obs = {hz.stall_if, hz.stall_id, hz.bubble_ex, hz.flush_id, hz.freeze,
             hz.fwd_a, hz.fwd_b, hz.mem_timeout};
      x = sb.pop_front();
      n_cmp++;
      assert (obs === x.val)
      else begin
         n_err++;
         $error("FAIL %s: observed=%b expected=%b", x.tag, obs, x.val);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      nop();
      hz.ex_redirect = 1'b0;
      hz.mem_wait    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      cyc("reset", ev(IDLE, 2'b00, 2'b00, 1'b0));

      // lw x5 ; add x6,x5,x1 -> one load-use bubble, then fwd_a=01
      id(1, 5'd2, 5'd0, 1, 0, 5'd5, 1, 1);  cyc("lu_load",    ev(IDLE, 2'b00, 2'b00, 1'b0));
      id(1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 0);  cyc("lu_stall",   ev(LU,   2'b00, 2'b00, 1'b0));
                                            cyc("lu_release", ev(IDLE, 2'b00, 2'b00, 1'b0));
      nop();                                cyc("lu_fwd",     ev(IDLE, 2'b01, 2'b00, 1'b0));

      // add x3 ; independent ; sub x4,x3,x3 -> no stall, both selects 10
      id(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0);  cyc("raw_prod",   ev(IDLE, 2'b00, 2'b00, 1'b0));
      id(1, 5'd8, 5'd9, 1, 1, 5'd7, 1, 0);  cyc("raw_indep",  ev(IDLE, 2'b00, 2'b00, 1'b0));
      id(1, 5'd3, 5'd3, 1, 1, 5'd4, 1, 0);  cyc("raw_sub",    ev(IDLE, 2'b00, 2'b00, 1'b0));
      nop();                                cyc("raw_fwd_wb", ev(IDLE, 2'b10, 2'b10, 1'b0));

      // back-to-back ALU producer -> 01; producer already in WB -> 00
      id(1, 5'd1, 5'd1, 1, 1, 5'd11, 1, 0); cyc("alu_prod",   ev(IDLE, 2'b00, 2'b00, 1'b0));
      id(1, 5'd11, 5'd4, 1, 1, 5'd12, 1, 0); cyc("alu_use",   ev(IDLE, 2'b00, 2'b00, 1'b0));

      // write to x0 never forwards
      id(1, 5'd1, 5'd1, 1, 1, 5'd0, 1, 0);  cyc("x0_prod",    ev(IDLE, 2'b01, 2'b00, 1'b0));
      id(1, 5'd0, 5'd0, 1, 1, 5'd13, 1, 0); cyc("x0_use",     ev(IDLE, 2'b00, 2'b00, 1'b0));
      nop();                                cyc("x0_fwd",     ev(IDLE, 2'b00, 2'b00, 1'b0));

      // redirect overrides load-use
      id(1, 5'd2, 5'd0, 1, 0, 5'd5, 1, 1);  cyc("rdr_load",   ev(IDLE, 2'b00, 2'b00, 1'b0));
      id(1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 0);
      hz.ex_redirect = 1'b1;                cyc("rdr_flush",  ev(RDR,  2'b00, 2'b00, 1'b0));
      hz.ex_redirect = 1'b0;                cyc("rdr_after",  ev(IDLE, 2'b00, 2'b00, 1'b0));
      id(1, 5'd1, 5'd1, 1, 1, 5'd20, 1, 0); cyc("rdr_fwd",    ev(IDLE, 2'b01, 2'b00, 1'b0));

      // 20-cycle LSU wait: freeze throughout, single timeout pulse at wait cycle 16
      id(1, 5'd20, 5'd20, 1, 1, 5'd21, 1, 0);
      hz.mem_wait = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         hz.ex_redirect = (k >= 18);
         cyc($sformatf("wait_%0d", k), ev(FRZ, 2'b00, 2'b00, k == 16));
      end
      hz.mem_wait = 1'b0;
      hz.ex_redirect = 1'b0;                cyc("wait_resume", ev(IDLE, 2'b00, 2'b00, 1'b0));
      nop();
      hz.ex_redirect = 1'b1;                cyc("resume_fwd",  ev(RDR,  2'b01, 2'b01, 1'b0));
      hz.mem_wait = 1'b1;                   cyc("frz_rdr",     ev(FRZ,  2'b00, 2'b00, 1'b0));
      hz.mem_wait = 1'b0;                   cyc("rdr_held",    ev(RDR,  2'b00, 2'b00, 1'b0));
      hz.ex_redirect = 1'b0;

      // reset in the middle of a wait with live forwarding
      id(1, 5'd1, 5'd1, 1, 1, 5'd22, 1, 0);  cyc("rst_prod",  ev(IDLE, 2'b00, 2'b00, 1'b0));
      id(1, 5'd22, 5'd22, 1, 1, 5'd23, 1, 0); cyc("rst_use",  ev(IDLE, 2'b00, 2'b00, 1'b0));
      nop();
      hz.mem_wait = 1'b1;                   cyc("rst_wait",    ev(FRZ,  2'b01, 2'b01, 1'b0));
      rst = 1'b1;                           cyc("rst_in_wait", ev(FRZ,  2'b01, 2'b01, 1'b0));
      rst = 1'b0;
      hz.mem_wait = 1'b0;
      id(1, 5'd23, 5'd22, 1, 1, 5'd24, 1, 0); cyc("rst_clean", ev(IDLE, 2'b00, 2'b00, 1'b0));
      nop();                                cyc("rst_no_stale", ev(IDLE, 2'b00, 2'b00, 1'b0));

      // wait counter restarts from zero after reset
      hz.mem_wait = 1'b1;
      for (int k = 1; k <= 17; k++)
         cyc($sformatf("wait2_%0d", k), ev(FRZ, 2'b00, 2'b00, k == 16));
      hz.mem_wait = 1'b0;                   cyc("wait2_resume", ev(IDLE, 2'b00, 2'b00, 1'b0));

      // freeze outranks load-use; the stall appears once the freeze drops
      id(1, 5'd2, 5'd0, 1, 0, 5'd5, 1, 1);  cyc("flu_load",    ev(IDLE, 2'b00, 2'b00, 1'b0));
      id(1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 0);
      hz.mem_wait = 1'b1;                   cyc("flu_frozen",  ev(FRZ,  2'b00, 2'b00, 1'b0));
      hz.mem_wait = 1'b0;                   cyc("flu_stall",   ev(LU,   2'b00, 2'b00, 1'b0));
                                            cyc("flu_release", ev(IDLE, 2'b00, 2'b00, 1'b0));
      nop();                                cyc("flu_fwd",     ev(IDLE, 2'b01, 2'b00, 1'b0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
